// File: rtl/alu_input_sequencer_if.sv
// Board-side and ALU-side signal bundle of the ALU input sequencer.
// The sequencer drives operands/op/result; the board drives switches/buttons.
interface alu_input_sequencer_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic [NB_DATA-1:0] i_sw;
    logic [2:0]         i_btn;
    logic [NB_DATA-1:0] i_result;
    logic [NB_DATA-1:0] o_data_A;
    logic [NB_DATA-1:0] o_data_B;
    logic [NB_OP-1:0]   o_op;
    logic [NB_DATA-1:0] o_result;
    logic               o_valid;
    logic [2:0]         o_state;

    modport master (
        input  i_sw, i_btn, i_result,
        output o_data_A, o_data_B, o_op, o_result, o_valid, o_state
    );

    modport slave (
        output i_sw, i_btn, i_result,
        input  o_data_A, o_data_B, o_op, o_result, o_valid, o_state
    );
endinterface

// File: rtl/alu_input_sequencer.sv
// Button-driven operand/opcode sequencer for the switch/LED ALU board:
// debounced buttons step a guided FSM that loads A, B, op and latches the result.
module alu_input_sequencer #(
    parameter int NB_DATA   = 8,
    parameter int NB_OP     = 6,
    parameter int DB_CYCLES = 1000000,
    parameter int NB_DB     = $clog2(DB_CYCLES + 1)
) (
    input logic                   i_clk,
    input logic                   i_reset,
    alu_input_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    localparam logic [NB_DB-1:0] CNT_MAX = NB_DB'(DB_CYCLES - 1);

    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_deb;
    logic [2:0]       r_deb_q;
    logic [NB_DB-1:0] r_cnt [3];

    logic [2:0] w_pulse;
    logic       w_clr;
    logic       w_can;
    logic       w_cnf;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_q <= '0;
            r_cnt   <= '{default: '0};
        end else begin
            r_sync1 <= bus.i_btn;
            r_sync2 <= r_sync1;
            r_deb_q <= r_deb;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + NB_DB'(1);
                end
            end
        end
    end

    // Rising edge of the debounced level; clear beats cancel beats confirm.
    assign w_pulse = r_deb & ~r_deb_q;
    assign w_clr   = w_pulse[2];
    assign w_can   = w_pulse[1] & ~w_pulse[2];
    assign w_cnf   = w_pulse[0] & ~(|w_pulse[2:1]);

    state_t r_state;
    state_t w_next;
    logic   w_ld_a;
    logic   w_ld_b;
    logic   w_ld_op;
    logic   w_exec;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= WAIT_A;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_ld_a  = 1'b0;
        w_ld_b  = 1'b0;
        w_ld_op = 1'b0;
        w_exec  = 1'b0;
        if (w_clr) begin
            w_next = WAIT_A;
        end else begin
            unique case (r_state)
                WAIT_A: begin
                    if (w_cnf) begin
                        w_next = WAIT_B;
                        w_ld_a = 1'b1;
                    end
                end
                WAIT_B: begin
                    if (w_can) begin
                        w_next = WAIT_A;
                    end else if (w_cnf) begin
                        w_next = WAIT_OP;
                        w_ld_b = 1'b1;
                    end
                end
                WAIT_OP: begin
                    if (w_can) begin
                        w_next = WAIT_B;
                    end else if (w_cnf) begin
                        w_next  = EXEC;
                        w_ld_op = 1'b1;
                    end
                end
                EXEC: begin
                    w_next = SHOW;
                    w_exec = 1'b1;
                end
                SHOW: begin
                    if (w_can)      w_next = WAIT_OP;
                    else if (w_cnf) w_next = WAIT_A;
                end
                default: w_next = WAIT_A;
            endcase
        end
    end

    logic [NB_DATA-1:0] r_data_a;
    logic [NB_DATA-1:0] r_data_b;
    logic [NB_OP-1:0]   r_op;
    logic [NB_DATA-1:0] r_result;
    logic               r_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset || w_clr) begin
            r_data_a <= '0;
            r_data_b <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_exec;
            if (w_ld_a)  r_data_a <= bus.i_sw;
            if (w_ld_b)  r_data_b <= bus.i_sw;
            if (w_ld_op) r_op     <= bus.i_sw[NB_OP-1:0];
            if (w_exec)  r_result <= bus.i_result;
        end
    end

    assign bus.o_data_A = r_data_a;
    assign bus.o_data_B = r_data_b;
    assign bus.o_op     = r_op;
    assign bus.o_result = r_result;
    assign bus.o_valid  = r_valid;
    assign bus.o_state  = r_state;
endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed and randomized bench for alu_input_sequencer with a per-press
// behavioural model of the operand/op/result sequence.
module tb_alu_input_sequencer;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_input_sequencer_if #(.NB_DATA(8), .NB_OP(6)) bus ();

    assign bus.i_result = bus.o_data_A + bus.o_data_B;

    alu_input_sequencer #(
        .NB_DATA(8),
        .NB_OP(6),
        .DB_CYCLES(DB)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int vcnt = 0;
    int mexec = 0;
    int mst = 0;
    logic [7:0] mA = '0;
    logic [7:0] mB = '0;
    logic [5:0] mop = '0;
    logic [7:0] mres = '0;

    always @(negedge clk) if (bus.o_valid === 1'b1) vcnt++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_state"}, 32'(bus.o_state), 32'(mst));
        chk({tag, "_A"}, 32'(bus.o_data_A), 32'(mA));
        chk({tag, "_B"}, 32'(bus.o_data_B), 32'(mB));
        chk({tag, "_op"}, 32'(bus.o_op), 32'(mop));
        chk({tag, "_res"}, 32'(bus.o_result), 32'(mres));
        chk({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
        chk({tag, "_vcnt"}, 32'(vcnt), 32'(mexec));
    endtask

    // Effect of one accepted press; returns the state seen on the update edge.
    function automatic int mdl_apply(input logic [2:0] m, input logic [7:0] sw);
        if (m[2]) begin
            mA = '0; mB = '0; mop = '0; mres = '0; mst = 0;
            return 0;
        end
        if (m[1]) begin
            case (mst)
                1: mst = 0;
                2: mst = 1;
                4: mst = 2;
                default: ;
            endcase
            return mst;
        end
        case (mst)
            0: begin mA = sw; mst = 1; end
            1: begin mB = sw; mst = 2; end
            2: begin
                mop = sw[5:0];
                mres = 8'(mA + mB);
                mexec++;
                mst = 4;
                return 3;
            end
            4: mst = 0;
            default: ;
        endcase
        return mst;
    endfunction

    task automatic mdl_reset();
        mA = '0; mB = '0; mop = '0; mres = '0; mst = 0;
    endtask

    // Buttons already driven just after a negedge: the update must land
    // exactly on edge DB+2 counted from the first sampling edge.
    task automatic expect_press(input string tag, input int pre, input int mid);
        repeat (DB + 2) @(negedge clk);
        chk({tag, "_lat_early"}, 32'(bus.o_state), 32'(pre));
        @(negedge clk);
        chk({tag, "_lat_edge"}, 32'(bus.o_state), 32'(mid));
        bus.i_btn = 3'b000;
        repeat (DB + 6) @(negedge clk);
        check_all(tag);
    endtask

    task automatic press(input string tag, input logic [2:0] m,
                         input logic [7:0] sw);
        int pre;
        int mid;
        bus.i_sw  = sw;
        bus.i_btn = m;
        pre = mst;
        mid = mdl_apply(m, sw);
        expect_press(tag, pre, mid);
    endtask

    logic [2:0] tbl [8];

    initial begin
        tbl = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd4, 3'd3, 3'd5};
        rst = 1'b1;
        bus.i_btn = 3'b000;
        bus.i_sw = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_all("reset");

        press("seqA", 3'b001, 8'h05);
        press("seqB", 3'b001, 8'h03);
        press("seqOp", 3'b001, 8'h20);
        chk("seq_result", 32'(bus.o_result), 32'h08);
        chk("seq_state", 32'(bus.o_state), 32'd4);

        press("toA", 3'b001, 8'h00);
        bus.i_sw = 8'hAA;
        bus.i_btn = 3'b001;
        repeat (3) @(negedge clk);
        bus.i_btn = 3'b000;
        repeat (DB + 6) @(negedge clk);
        check_all("glitch");

        bus.i_btn = 3'b001;
        @(negedge clk);
        bus.i_btn = 3'b000;
        @(negedge clk);
        press("bounce", 3'b001, 8'h05);

        press("canB", 3'b001, 8'h03);
        press("can1", 3'b010, 8'h00);
        press("canB2", 3'b001, 8'h07);
        chk("can_B", 32'(bus.o_data_B), 32'h07);
        press("canOp", 3'b001, 8'h20);
        press("showCan", 3'b010, 8'h00);
        press("showOp", 3'b001, 8'h22);
        chk("show_res", 32'(bus.o_result), 32'h0C);

        press("simA", 3'b001, 8'h00);
        press("simB", 3'b001, 8'h11);
        press("simClr", 3'b101, 8'h99);
        press("sim2A", 3'b001, 8'h12);
        press("sim2B", 3'b001, 8'h34);
        press("sim2C", 3'b010, 8'h00);
        press("simCanCnf", 3'b011, 8'h44);
        chk("simcc_B", 32'(bus.o_data_B), 32'h34);

        begin
            int mid;
            bus.i_sw = 8'h66;
            mid = mdl_apply(3'b001, 8'h66);
            bus.i_btn = 3'b001;
            repeat (50) @(negedge clk);
            bus.i_btn = 3'b000;
            repeat (DB + 6) @(negedge clk);
            check_all("held");
        end

        press("rstB", 3'b001, 8'h21);
        begin
            int pre;
            int mid;
            bus.i_sw = 8'h09;
            bus.i_btn = 3'b001;
            repeat (3) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            mdl_reset();
            check_all("rst_mid");
            pre = mst;
            mid = mdl_apply(3'b001, 8'h09);
            expect_press("rst_held", pre, mid);
        end

        for (int i = 0; i < 30; i++) begin
            logic [2:0] m;
            logic [7:0] sw;
            m = tbl[$urandom_range(0, 7)];
            sw = 8'($urandom);
            press($sformatf("rnd%0d", i), m, sw);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_input_sequencer.md
# alu_input_sequencer

Button-driven input sequencer for the switch/LED ALU lab board. It replaces ad-hoc per-button operand loading with the following pieces:

- a synchronised, debounced, edge-detected button path;
- a guided state machine that captures operand A, operand B and the opcode from the switches in order;
- a registered result stage with a valid pulse.

It sits between the board I/O and the combinational ALU. It drives the ALU operand and op inputs and captures the ALU output.

## Interface
- NB_DATA, 8, operand/result width; switch bus width
- NB_OP, 6, opcode width; must satisfy NB_OP <= NB_DATA
- DB_CYCLES, 1000000, consecutive stable synchronised samples needed to accept a button level change; must be >= 2
- NB_DB, $clog2(DB_CYCLES+1), debounce counter width

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_sw  in  NB_DATA  switch value captured on confirm
- i_btn  in  3  raw buttons, asynchronous: [0] confirm, [1] cancel (step back), [2] clear
- i_result  in  NB_DATA  combinational ALU output
- o_data_A  out  NB_DATA  operand A register to the ALU
- o_data_B  out  NB_DATA  operand B register to the ALU
- o_op  out  NB_OP  opcode register to the ALU
- o_result  out  NB_DATA  registered result for the LEDs
- o_valid  out  1  one-cycle pulse when o_result is updated
- o_state  out  3  current FSM state, for status LEDs

## Operation
**Button path** (per button, independently):
- Two-flop synchroniser produces s.
- Debounce:
  - Debounced level deb and counter cnt.
  - If s == deb, cnt <= 0.
  - Else if cnt == DB_CYCLES-1, deb <= s and cnt <= 0.
  - Else cnt <= cnt+1.
- Press pulse = deb & ~deb_q, where deb_q is deb delayed one cycle. The pulse is high for exactly one cycle per accepted press.
- Release events produce no action.

**FSM states and encodings:**
- WAIT_A=0: confirm captures i_sw into o_data_A and moves to WAIT_B.
- WAIT_B=1: confirm captures i_sw into o_data_B and moves to WAIT_OP. Cancel moves to WAIT_A.
- WAIT_OP=2: confirm captures i_sw[NB_OP-1:0] into o_op and moves to EXEC. Cancel moves to WAIT_B.
- EXEC=3: lasts one cycle, unconditionally. o_result <= i_result, o_valid <= 1, then moves to SHOW.
- SHOW=4: confirm moves to WAIT_A. Cancel moves to WAIT_OP, so a new op can be applied to the same operands.
- Encodings 5–7 are unreachable; if entered, the FSM returns to WAIT_A.

**Button rules:**
- Cancel in WAIT_A: no effect.
- Cancel or confirm never modifies any register other than the one named above. Previously captured operands are retained when stepping back.
- Clear, in any state including EXEC, does the following:
  - zeroes o_data_A, o_data_B, o_op, o_result and o_valid;
  - moves the FSM to WAIT_A.
- Simultaneous pulses: clear > cancel > confirm. Only the highest-priority pulse takes effect.

**Result register:** o_result holds its value until the next EXEC, clear or reset.

## Timing
- Reset takes effect at the clock edge where i_reset is sampled high. It sets:
  - all outputs to 0;
  - o_state to WAIT_A;
  - synchroniser flops, deb, deb_q and cnt to 0.
- Reset mid-debounce discards the partial count.
- A button held high through reset is accepted as a new press once stable for DB_CYCLES after reset is released.
- Button press latency, with the raw input first sampled high at edge 0:
  - s is high after edge 1.
  - deb rises at edge DB_CYCLES+1.
  - The FSM/register update occurs at edge DB_CYCLES+2.
- Glitch rejection: a raw pulse whose synchronised high lasts fewer than DB_CYCLES cycles produces no press. A bounce resets cnt to 0.
- EXEC latency:
  - o_result and o_valid update at the edge that leaves EXEC, i.e. one cycle after the op is captured.
  - o_valid is deasserted the next edge.
- i_result must be valid combinationally from o_data_A, o_data_B and o_op within one cycle.

## Test plan
All scenarios use DB_CYCLES=4, NB_DATA=8, NB_OP=6. The bench models the ALU as i_result = o_data_A + o_data_B.

- **Full sequence:** set sw=0x05 and confirm; sw=0x03 and confirm; sw=0x20 and confirm.
  - Required: o_data_A=0x05, o_data_B=0x03, o_op=0x20, o_result=0x08.
  - Required: o_valid high exactly one cycle, o_state ending at 4.
  - Required: each press takes effect exactly DB_CYCLES+2 edges after the raw rise.
- **Glitch rejection:** raw confirm high for 3 cycles in WAIT_A.
  - Required: no state change and o_data_A unchanged.
  - Also: a bounce pattern of 1-0-1 followed by a steady high yields exactly one press.
- **Cancel path:** from WAIT_OP with B=0x03, cancel, set sw=0x07 and confirm.
  - Required: state goes 2→1→2, B=0x07, A unchanged.
  - Then, from SHOW, cancel and confirm op 0x22: state returns to 2 and then 4, and a second o_valid pulse occurs.
- **Simultaneous pulses:** confirm and clear in WAIT_B on the same cycle.
  - Required: state 0, and all data outputs 0x00.
  - Also: cancel and confirm together in WAIT_B goes to WAIT_A with B unchanged.
- **Held button:** confirm held high for 50 cycles in WAIT_A.
  - Required: exactly one advance, to WAIT_B.
- **Reset mid-operation:** assert i_reset in WAIT_OP with cnt partially counted.
  - Required: all outputs 0 and o_state 0 on the next edge.
  - Required: a button held across reset is accepted once, DB_CYCLES+2 edges after release.
